launch_ctrl: RTL and testbench

- Sits directly downstream of the player cursor stage in the missile-command datapath.
- Watches the active-low fire button and latches the cursor grid position (x 0..3, y 0..2) on each press.
- Presents each latched shot to the missile engine over a valid/ready handshake.
- Tracks remaining interceptor ammunition and enforces a cooldown between launches.

---
 rtl/mc_pkg.sv | 15 +
 rtl/launch_ctrl_if.sv | 13 +
 rtl/fire_sync.sv | 32 +++
 rtl/launch_ctrl.sv | 100 ++++++++++
 tb/tb_launch_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared missile-command definitions: coordinate width, cursor grid limits
// and the launch controller state encoding.
package mc_pkg;

  localparam int COORD_W        = 4;
  localparam int DEF_GRID_X_MAX = 3;
  localparam int DEF_GRID_Y_MAX = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COOL = 2'd2
  } launch_state_t;

endpackage

// File: rtl/launch_ctrl_if.sv
// Shot handshake between the launch controller (master) and the missile engine (slave).
interface launch_ctrl_if;
  import mc_pkg::*;

  logic               launch_valid;
  logic               launch_ready;
  logic [COORD_W-1:0] launch_x;
  logic [COORD_W-1:0] launch_y;

  modport master (output launch_valid, output launch_x, output launch_y, input  launch_ready);
  modport slave  (input  launch_valid, input  launch_x, input  launch_y, output launch_ready);

endinterface

// File: rtl/fire_sync.sv
// Two-flop synchronizer for an active-low button plus a one-cycle press pulse
// on each released-to-pressed transition of the synchronized level.
module fire_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic       s1, s2;
  logic       prev;
  logic [1:0] live;

  // live marks when s2 carries a real sample rather than its reset value, so a
  // button held through reset is not mistaken for a fresh press on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      live <= 2'b00;
      prev <= 1'b0;
    end else begin
      s1   <= btn_n;
      s2   <= s1;
      live <= {live[0], 1'b1};
      prev <= s2 & live[1];
    end
  end

  assign press = prev & ~s2;

endmodule

// File: rtl/launch_ctrl.sv
// Latches the cursor on each fire press and offers it to the missile engine,
// tracking ammunition and enforcing a cooldown after every accepted launch.
import mc_pkg::*;

module launch_ctrl #(
  parameter int AMMO_MAX        = 10,
  parameter int COOLDOWN_CYCLES = 50000000,
  parameter int GRID_X_MAX      = DEF_GRID_X_MAX,
  parameter int GRID_Y_MAX      = DEF_GRID_Y_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire_n,
  input  logic [COORD_W-1:0] cursor_x,
  input  logic [COORD_W-1:0] cursor_y,
  input  logic               new_wave,
  launch_ctrl_if.master      lc,
  output logic [3:0]         ammo,
  output logic               ammo_empty,
  output logic               cooling,
  output logic               fire_reject
);

  launch_state_t      state;
  logic [31:0]        cnt;
  logic               press;
  logic               in_range;
  logic               transfer;
  logic               valid_q;
  logic [COORD_W-1:0] x_q, y_q;

  fire_sync u_fire_sync (
    .clk   (clk),
    .rst   (rst),
    .btn_n (fire_n),
    .press (press)
  );

  assign in_range = (cursor_x <= COORD_W'(GRID_X_MAX)) && (cursor_y <= COORD_W'(GRID_Y_MAX));
  assign transfer = (state == REQ) && lc.launch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cooling     <= 1'b0;
      fire_reject <= 1'b0;
      cnt         <= '0;
      ammo        <= 4'(AMMO_MAX);
    end else begin
      fire_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            if ((ammo != 4'd0) && in_range) begin
              x_q     <= cursor_x;
              y_q     <= cursor_y;
              valid_q <= 1'b1;
              state   <= REQ;
            end else begin
              fire_reject <= 1'b1;
            end
          end
        end
        REQ: begin
          if (lc.launch_ready) begin
            valid_q <= 1'b0;
            cooling <= 1'b1;
            cnt     <= '0;
            state   <= COOL;
          end
        end
        COOL: begin
          if (cnt == 32'(COOLDOWN_CYCLES - 1)) begin
            cooling <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Refill takes priority over a same-cycle launch.
      if (new_wave) begin
        ammo <= 4'(AMMO_MAX);
      end else if (transfer) begin
        ammo <= ammo - 4'd1;
      end
    end
  end

  assign lc.launch_valid = valid_q;
  assign lc.launch_x     = x_q;
  assign lc.launch_y     = y_q;
  assign ammo_empty      = (ammo == 4'd0);

endmodule

// File: tb/tb_launch_ctrl.sv
// Scenario bench for launch_ctrl with AMMO_MAX=3, COOLDOWN_CYCLES=4; accepted
// shots are queued as expected targets and popped when the engine takes them.
module tb_launch_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fire_n = 1'b1;
  logic [3:0] cursor_x = 4'd0;
  logic [3:0] cursor_y = 4'd0;
  logic       new_wave = 1'b0;
  logic [3:0] ammo;
  logic       ammo_empty;
  logic       cooling;
  logic       fire_reject;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] exp_q[$];

  launch_ctrl_if lc();

  launch_ctrl #(
    .AMMO_MAX        (3),
    .COOLDOWN_CYCLES (4),
    .GRID_X_MAX      (3),
    .GRID_Y_MAX      (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fire_n      (fire_n),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .new_wave    (new_wave),
    .lc          (lc),
    .ammo        (ammo),
    .ammo_empty  (ammo_empty),
    .cooling     (cooling),
    .fire_reject (fire_reject)
  );

  always #5 clk = ~clk;

  // Transfers happen on the next rising edge; observe them half a cycle early.
  always @(negedge clk) begin
    if (!rst && lc.launch_valid && lc.launch_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL transfer_unexpected: got x=%0d y=%0d, required no transfer", lc.launch_x, lc.launch_y);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({lc.launch_x, lc.launch_y} !== e) begin
          n_fails++;
          $display("FAIL transfer_target: got x=%0d y=%0d, required x=%0d y=%0d",
                   lc.launch_x, lc.launch_y, e[7:4], e[3:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single-cycle press; returns just after the edge that presents launch_valid.
  task automatic do_press();
    fire_n = 1'b0;
    tick(1);
    fire_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    lc.launch_ready = 1'b0;
    rst = 1'b1;
    tick(2);
    n_checks++;
    if ({lc.launch_valid, ammo, ammo_empty, cooling, fire_reject, lc.launch_x, lc.launch_y} !== {1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      n_fails++;
      $display("FAIL reset_state: got valid=%b ammo=%0d empty=%b cool=%b rej=%b x=%0d y=%0d, required 0 3 0 0 0 0 0",
               lc.launch_valid, ammo, ammo_empty, cooling, fire_reject, lc.launch_x, lc.launch_y);
    end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_basic_launch();
    lc.launch_ready = 1'b1;
    cursor_x = 4'd1; cursor_y = 4'd0;
    exp_q.push_back({4'd2, 4'd1});
    fire_n = 1'b0;
    tick(1);
    n_checks++;
    if (lc.launch_valid !== 1'b0) begin n_fails++; $display("FAIL basic_latency_e0: got valid=%b, required 0", lc.launch_valid); end
    tick(1);
    cursor_x = 4'd2; cursor_y = 4'd1;
    n_checks++;
    if (lc.launch_valid !== 1'b0) begin n_fails++; $display("FAIL basic_latency_e1: got valid=%b, required 0", lc.launch_valid); end
    tick(1);
    n_checks++;
    if ({lc.launch_valid, lc.launch_x, lc.launch_y} !== {1'b1, 4'd2, 4'd1}) begin
      n_fails++;
      $display("FAIL basic_valid: got valid=%b x=%0d y=%0d, required 1 2 1", lc.launch_valid, lc.launch_x, lc.launch_y);
    end
    tick(1);
    n_checks++;
    if ({lc.launch_valid, ammo, cooling} !== {1'b0, 4'd2, 1'b1}) begin
      n_fails++;
      $display("FAIL basic_after_transfer: got valid=%b ammo=%0d cool=%b, required 0 2 1", lc.launch_valid, ammo, cooling);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++;
      if (cooling !== 1'b1) begin n_fails++; $display("FAIL basic_cooling_%0d: got %b, required 1", i, cooling); end
    end
    tick(1);
    n_checks++;
    if (cooling !== 1'b0) begin n_fails++; $display("FAIL basic_cooling_end: got %b, required 0", cooling); end
    // Button still held: must not auto-repeat.
    tick(6);
    fire_n = 1'b1;
    tick(4);
    n_checks++;
    if ({lc.launch_valid, ammo} !== {1'b0, 4'd2}) begin
      n_fails++;
      $display("FAIL basic_no_repeat: got valid=%b ammo=%0d, required 0 2", lc.launch_valid, ammo);
    end
  endtask

  task automatic test_backpressure();
    lc.launch_ready = 1'b0;
    cursor_x = 4'd3; cursor_y = 4'd2;
    exp_q.push_back({4'd3, 4'd2});
    do_press();
    cursor_x = 4'd0; cursor_y = 4'd0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({lc.launch_valid, lc.launch_x, lc.launch_y, ammo} !== {1'b1, 4'd3, 4'd2, 4'd2}) begin
        n_fails++;
        $display("FAIL bp_hold_%0d: got valid=%b x=%0d y=%0d ammo=%0d, required 1 3 2 2",
                 i, lc.launch_valid, lc.launch_x, lc.launch_y, ammo);
      end
      tick(1);
    end
    lc.launch_ready = 1'b1;
    tick(1);
    n_checks++;
    if ({lc.launch_valid, ammo} !== {1'b0, 4'd1}) begin
      n_fails++;
      $display("FAIL bp_transfer: got valid=%b ammo=%0d, required 0 1", lc.launch_valid, ammo);
    end
    tick(6);
    n_checks++;
    if (ammo !== 4'd1) begin n_fails++; $display("FAIL bp_single_dec: got ammo=%0d, required 1", ammo); end
  endtask

  task automatic test_exhaustion();
    new_wave = 1'b1;
    tick(1);
    new_wave = 1'b0;
    n_checks++;
    if (ammo !== 4'd3) begin n_fails++; $display("FAIL exh_refill_start: got ammo=%0d, required 3", ammo); end
    lc.launch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cursor_x = 4'(i); cursor_y = 4'(i % 3);
      exp_q.push_back({4'(i), 4'(i % 3)});
      do_press();
      tick(6);
    end
    n_checks++;
    if ({ammo, ammo_empty} !== {4'd0, 1'b1}) begin
      n_fails++;
      $display("FAIL exh_empty: got ammo=%0d empty=%b, required 0 1", ammo, ammo_empty);
    end
    fire_n = 1'b0;
    tick(1);
    fire_n = 1'b1;
    tick(1);
    n_checks++;
    if (fire_reject !== 1'b0) begin n_fails++; $display("FAIL exh_reject_early: got %b, required 0", fire_reject); end
    tick(1);
    n_checks++;
    if ({fire_reject, lc.launch_valid} !== 2'b10) begin
      n_fails++;
      $display("FAIL exh_reject: got rej=%b valid=%b, required 1 0", fire_reject, lc.launch_valid);
    end
    tick(1);
    n_checks++;
    if ({fire_reject, lc.launch_valid} !== 2'b00) begin
      n_fails++;
      $display("FAIL exh_reject_width: got rej=%b valid=%b, required 0 0", fire_reject, lc.launch_valid);
    end
    new_wave = 1'b1;
    tick(1);
    new_wave = 1'b0;
    n_checks++;
    if ({ammo, ammo_empty} !== {4'd3, 1'b0}) begin
      n_fails++;
      $display("FAIL exh_new_wave: got ammo=%0d empty=%b, required 3 0", ammo, ammo_empty);
    end
  endtask

  task automatic test_range_and_drop();
    cursor_x = 4'd3; cursor_y = 4'd3;
    do_press();
    n_checks++;
    if ({fire_reject, lc.launch_valid, ammo} !== {1'b1, 1'b0, 4'd3}) begin
      n_fails++;
      $display("FAIL range_reject: got rej=%b valid=%b ammo=%0d, required 1 0 3", fire_reject, lc.launch_valid, ammo);
    end
    tick(3);
    cursor_x = 4'd1; cursor_y = 4'd2;
    exp_q.push_back({4'd1, 4'd2});
    do_press();
    tick(1);
    // In COOL now; this press must vanish without a trace.
    do_press();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({fire_reject, lc.launch_valid} !== 2'b00) begin
        n_fails++;
        $display("FAIL drop_cool_%0d: got rej=%b valid=%b, required 0 0", i, fire_reject, lc.launch_valid);
      end
      tick(1);
    end
    n_checks++;
    if (ammo !== 4'd2) begin n_fails++; $display("FAIL drop_ammo: got %0d, required 2", ammo); end
  endtask

  task automatic test_simultaneous();
    cursor_x = 4'd0; cursor_y = 4'd1;
    exp_q.push_back({4'd0, 4'd1});
    do_press();
    tick(6);
    n_checks++;
    if (ammo !== 4'd1) begin n_fails++; $display("FAIL simul_pre: got ammo=%0d, required 1", ammo); end
    lc.launch_ready = 1'b0;
    cursor_x = 4'd2; cursor_y = 4'd2;
    exp_q.push_back({4'd2, 4'd2});
    do_press();
    tick(2);
    lc.launch_ready = 1'b1;
    new_wave = 1'b1;
    tick(1);
    new_wave = 1'b0;
    n_checks++;
    if ({ammo, lc.launch_valid, cooling} !== {4'd3, 1'b0, 1'b1}) begin
      n_fails++;
      $display("FAIL simul_refill: got ammo=%0d valid=%b cool=%b, required 3 0 1", ammo, lc.launch_valid, cooling);
    end
    tick(6);
  endtask

  task automatic test_reset_mid_op();
    cursor_x = 4'd1; cursor_y = 4'd1;
    exp_q.push_back({4'd1, 4'd1});
    do_press();
    tick(6);
    lc.launch_ready = 1'b0;
    cursor_x = 4'd3; cursor_y = 4'd0;
    do_press();
    n_checks++;
    if ({lc.launch_valid, ammo} !== {1'b1, 4'd2}) begin
      n_fails++;
      $display("FAIL rst_pre: got valid=%b ammo=%0d, required 1 2", lc.launch_valid, ammo);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++;
    if ({lc.launch_valid, ammo, cooling, lc.launch_x} !== {1'b0, 4'd3, 1'b0, 4'd0}) begin
      n_fails++;
      $display("FAIL rst_mid_req: got valid=%b ammo=%0d cool=%b x=%0d, required 0 3 0 0",
               lc.launch_valid, ammo, cooling, lc.launch_x);
    end
    lc.launch_ready = 1'b1;
    tick(3);
    fire_n = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_checks++;
      if ({lc.launch_valid, fire_reject} !== 2'b00) begin
        n_fails++;
        $display("FAIL rst_held_%0d: got valid=%b rej=%b, required 0 0", i, lc.launch_valid, fire_reject);
      end
    end
    fire_n = 1'b1;
    tick(3);
    cursor_x = 4'd2; cursor_y = 4'd0;
    lc.launch_ready = 1'b0;
    exp_q.push_back({4'd2, 4'd0});
    do_press();
    n_checks++;
    if ({lc.launch_valid, lc.launch_x, lc.launch_y} !== {1'b1, 4'd2, 4'd0}) begin
      n_fails++;
      $display("FAIL rst_repress: got valid=%b x=%0d y=%0d, required 1 2 0", lc.launch_valid, lc.launch_x, lc.launch_y);
    end
    lc.launch_ready = 1'b1;
    tick(7);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_launch();
    test_backpressure();
    test_exhaustion();
    test_range_and_drop();
    test_simultaneous();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
